// File: rtl/table_lookup.sv
// AES encryption-round T-table lookup for one 32-bit state column.
// Four independent byte lanes (S-box + xtime) feed a single output register stage.

module table_lookup_lane (
  input  logic [7:0]  b,
  output logic [31:0] t
);

  // FIPS-197 forward S-box, row = high nibble, column = low nibble.
  localparam logic [7:0] sbox_rom [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0] s;
  logic [7:0] m2;
  logic [7:0] m3;

  assign s  = sbox_rom[b];
  // xtime: multiply by {02} in GF(2^8), folding the carry back with the AES polynomial.
  assign m2 = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
  assign m3 = m2 ^ s;
  assign t  = {s, s, m3, m2};

endmodule

module table_lookup (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] state,
  output logic [31:0] p0,
  output logic [31:0] p1,
  output logic [31:0] p2,
  output logic [31:0] p3
);

  logic [31:0] t0;
  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] t3;

  table_lookup_lane u_lane0 (.b(state[31:24]), .t(t0));
  table_lookup_lane u_lane1 (.b(state[23:16]), .t(t1));
  table_lookup_lane u_lane2 (.b(state[15:8]),  .t(t2));
  table_lookup_lane u_lane3 (.b(state[7:0]),   .t(t3));

  // NOTE: non-blocking assignments keep all four words updating atomically on the edge;
  // reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
    end else begin
      // Word k carries lane k's T = {s, s, 3s, 2s} rotated right by 8*(k+1) bits (mod 32).
      p0 <= {t0[7:0],  t0[31:8]};
      p1 <= {t1[15:0], t1[31:16]};
      p2 <= {t2[23:0], t2[31:24]};
      p3 <= t3;
    end
  end

endmodule

// File: tb/tb_table_lookup.sv
// Self-checking bench for table_lookup: scoreboard queue of expected words, reference S-box
// derived independently from the GF(2^8) inverse plus the AES affine transform.

module tb_table_lookup;

  typedef struct packed {
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
  } words_t;

  logic        clk;
  logic        rst;
  logic [31:0] state;
  logic [31:0] p0;
  logic [31:0] p1;
  logic [31:0] p2;
  logic [31:0] p3;

  int unsigned errors;
  int unsigned checks;
  words_t      sb_q[$];
  logic [7:0]  sbox_ref [256];

  table_lookup dut (
    .clk   (clk),
    .rst   (rst),
    .state (state),
    .p0    (p0),
    .p1    (p1),
    .p2    (p2),
    .p3    (p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] a;
    logic [7:0] y;
    for (int x = 0; x < 256; x++) begin
      a   = x[7:0];
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        y = c[7:0];
        if (a != 8'h00 && gmul(a, y) == 8'h01) inv = y;
      end
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic words_t model(input logic [31:0] st);
    words_t     w;
    logic [7:0] s  [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = sbox_ref[st[31 - 8*i -: 8]];
      m2[i] = xt(s[i]);
      m3[i] = m2[i] ^ s[i];
    end
    w.p0 = {m2[0], s[0],  s[0],  m3[0]};
    w.p1 = {m3[1], m2[1], s[1],  s[1]};
    w.p2 = {s[2],  m3[2], m2[2], s[2]};
    w.p3 = {s[3],  s[3],  m3[3], m2[3]};
    return w;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic [31:0] st, input words_t exp_w);
    words_t e;
    rst   = r;
    state = st;
    sb_q.push_back(exp_w);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks += 4;
    if (p0 !== e.p0) begin
      errors++;
      $display("FAIL %s p0 state=%h: got %h, expected %h", tag, st, p0, e.p0);
    end
    if (p1 !== e.p1) begin
      errors++;
      $display("FAIL %s p1 state=%h: got %h, expected %h", tag, st, p1, e.p1);
    end
    if (p2 !== e.p2) begin
      errors++;
      $display("FAIL %s p2 state=%h: got %h, expected %h", tag, st, p2, e.p2);
    end
    if (p3 !== e.p3) begin
      errors++;
      $display("FAIL %s p3 state=%h: got %h, expected %h", tag, st, p3, e.p3);
    end
  endtask

  task automatic test_reset();
    step("reset0", 1'b1, 32'hdeadbeef, '0);
    step("reset1", 1'b1, 32'h12345678, '0);
    step("reset_release", 1'b0, 32'h0000_0000,
         '{p0: 32'hc6_63_63_a5, p1: 32'ha5_c6_63_63, p2: 32'h63_a5_c6_63, p3: 32'h63_63_a5_c6});
  endtask

  task automatic test_mixed();
    step("mixed", 1'b0, 32'h193de3be,
         '{p0: 32'hb3_d4_d4_67, p1: 32'h69_4e_27_27, p2: 32'h11_33_22_11, p3: 32'hae_ae_e9_47});
  endtask

  task automatic test_reduction();
    step("reduction", 1'b0, 32'hffffffff,
         '{p0: 32'h2c_16_16_3a, p1: 32'h3a_2c_16_16, p2: 32'h16_3a_2c_16, p3: 32'h16_16_3a_2c});
  endtask

  task automatic test_back_to_back();
    words_t w;
    step("b2b_0", 1'b0, 32'h00000000, model(32'h00000000));
    w = model(32'h01010101);
    w.p0 = 32'hf8_7c_7c_84;
    w.p3 = 32'h7c_7c_84_f8;
    step("b2b_1", 1'b0, 32'h01010101, w);
    step("b2b_2", 1'b0, 32'h193de3be, model(32'h193de3be));
  endtask

  task automatic test_midstream_reset();
    step("mid_a", 1'b0, 32'ha1b2c3d4, model(32'ha1b2c3d4));
    step("mid_rst", 1'b1, 32'h5a6b7c8d, '0);
    step("mid_b", 1'b0, 32'h5a6b7c8d, model(32'h5a6b7c8d));
    step("mid_c", 1'b0, 32'h80402010, model(32'h80402010));
  endtask

  task automatic test_exhaustive();
    logic [31:0] st;
    logic [31:0] base;
    for (int lane = 0; lane < 4; lane++) begin
      base = $urandom();
      for (int v = 0; v < 256; v++) begin
        st = base;
        st[31 - 8*lane -: 8] = v[7:0];
        step($sformatf("sweep_lane%0d", lane), 1'b0, st, model(st));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    state  = 32'h0;
    build_sbox();
    test_reset();
    test_mixed();
    test_reduction();
    test_back_to_back();
    test_midstream_reset();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
